yuv444_to_422: RTL and testbench
================================

Name: yuv444_to_422

Overview:
- Consumes the signed-chroma YUV 4:4:4 stream produced by the RGB-to-YUV stage.
- Converts it to a standard interleaved YUV 4:2:2 stream: 2-pixel chroma averaging, Y offset/clamp, chroma offset of 2^(PIXEL_WIDTH-1).
- Feeds the output formatter / USB packer with one 2*PIXEL_WIDTH word per pixel.

Parameters:
- PIXEL_WIDTH, 8, bit width of each Y/U/V component.
- Y_OFFSET, 0, unsigned offset added to Y before output (16 for studio-swing).

Ports:
- clk  in  1  pixel clock.
- resetb  in  1  asynchronous active-low reset.
- enable  in  1  1 = convert; 0 = bypass. Change only between frames.
- dvi  in  1  input beat valid.
- dtypei  in  `DTYPE_WIDTH  beat type, per dtypes.v.
- y  in  PIXEL_WIDTH  unsigned luma.
- u  in  PIXEL_WIDTH  signed two's-complement Cb.
- v  in  PIXEL_WIDTH  signed two's-complement Cr.
- meta_datai  in  16  per-beat metadata.
- dvo  out  1  output beat valid.
- dtypeo  out  `DTYPE_WIDTH  output beat type.
- datao  out  2*PIXEL_WIDTH  {C, Y}; C = offset U on even pixels, offset V on odd pixels.
- meta_datao  out  16  metadata of the emitted beat.

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous, active-low (resetb).
- Reset values: dvo=0, dtypeo=0, datao=0, meta_datao=0. Pair phase = EVEN. Held-pixel register cleared.
- Reset mid-operation: a held even pixel and all in-flight beats are discarded; no output until a new input beat arrives.
- Input rate: at most one beat per cycle; no backpressure.
- Beat classes:
  - Image beat: dvi=1 and `DTYPE_IS_IMAGE(dtypei).
  - Other beat: dvi=1, not an image beat.
  - Idle: dvi=0.
- Pair FSM (states EVEN, HOLD):
  - EVEN + image beat: store y/u/v/dtype/meta; go to HOLD. No output.
  - HOLD + image beat (odd pixel, cycle t):
    - Uavg = (Ue+Uo+1)>>>1 and Vavg = (Ve+Vo+1)>>>1, computed at PIXEL_WIDTH+1 bits signed, arithmetic shift. The result always fits PIXEL_WIDTH.
    - Even pixel emitted at t+1 with C = Uavg ^ MSB-mask (i.e. +2^(PIXEL_WIDTH-1)).
    - Odd pixel emitted at t+2 with C = Vavg + 2^(PIXEL_WIDTH-1).
    - Go to EVEN.
  - HOLD + idle or other beat at t (odd-length row or interrupted pair):
    - Held pixel flushed at t+1 as an even pixel using its own U.
    - No V is emitted for it. Go to EVEN.
  - Other beat at t (either state): emitted unchanged at t+2, datao = {u, y} of that beat. Phase is EVEN afterwards.
  - Idle in EVEN: no state change.
- Y path: Yout = y + Y_OFFSET, saturated to 2^PIXEL_WIDTH-1. Apply the same saturation to the flushed and paired pixels.
- dtypeo and meta_datao always travel with the pixel or beat they belong to.
- No output collisions: the scheduling above guarantees at most one emission per cycle for any legal input sequence. The verification engineer checks this with an assertion.
- Bypass (enable=0):
  - Every dvi beat is registered with latency 1: datao = {u, y}, no offsets, no averaging.
  - FSM held in EVEN.
- Between beats: dvo=0 on cycles with no emission; datao holds its last value.

Test Plan:
- PIXEL_WIDTH=8, Y_OFFSET=0. Back-to-back image beats (Y,U,V) = (100,-10,20) then (102,-20,31) at t, t+1 -> dvo at t+2 with datao=0x7164, at t+3 with datao=0x9A66; dtype/meta match the source pixels.
- Continuous row of 6 pixels -> 6 outputs on consecutive cycles starting 2 cycles after the 1st input. C alternates U,V; no gaps, no collisions.
- Odd-length row: pair, then a single pixel (50,-128,0), then dvi=0 at t -> datao=0x0032 at t+1, and no further pixel output.
- Y_OFFSET=16, pixel pair with Y=250 and Y=10 -> Y bytes 0xFF (saturated) and 0x1A.
- Header (non-image) beat between rows -> emitted unchanged 2 cycles later. A pixel held in HOLD when the header arrives is flushed the cycle before the header is emitted.
- resetb asserted while in HOLD -> outputs 0 immediately. After release, a fresh pair is output with no trace of the pre-reset pixel.
- enable=0 -> each beat output 1 cycle later as {u,y} raw, e.g. (100,-10,20) -> 0xF664.

Source files
------------

// File: rtl/yuv444_to_422.sv
// ---------------------------------------------------------------------------
// yuv444_to_422
//
// Converts the signed-chroma YUV 4:4:4 stream from the RGB-to-YUV stage into
// an interleaved YUV 4:2:2 stream, one 2*PIXEL_WIDTH word per pixel, for the
// output formatter / USB packer.
//
// Each pair of image pixels (even, odd) shares one averaged chroma sample:
// the even pixel carries the averaged U and the odd pixel carries the averaged
// V. Chroma is moved from two's complement to offset-binary by adding
// 2^(PIXEL_WIDTH-1). Luma gets Y_OFFSET added and is saturated to full scale.
//
// Ports:
//   clk         pixel clock
//   resetb      asynchronous active-low reset
//   enable      1 = convert, 0 = bypass (change only between frames)
//   dvi         input beat valid
//   dtypei      input beat type
//   y, u, v     input luma (unsigned), Cb and Cr (signed)
//   meta_datai  per-beat metadata
//   dvo         output beat valid
//   dtypeo      output beat type
//   datao       {C, Y}: C = offset U on even pixels, offset V on odd pixels
//   meta_datao  metadata of the emitted beat
//
// Latency (convert mode):
//   paired even pixel : 1 cycle after its odd partner arrives
//   paired odd pixel  : 2 cycles after it arrives
//   flushed pixel     : 1 cycle after the beat that breaks the pair
//   non-image beat    : 2 cycles, passed through as {u, y}
// Latency (bypass): every beat 1 cycle, passed through as {u, y}.
// ---------------------------------------------------------------------------

`timescale 1ns/1ps

// Fallback beat-type definitions for builds that do not pull in dtypes.v.
`ifndef DTYPE_WIDTH
`define DTYPE_WIDTH 4
`endif
`ifndef DTYPE_IS_IMAGE
`define DTYPE_IS_IMAGE(d) (((d) == 4'h1) || ((d) == 4'h2))
`endif

module yuv444_to_422 #(
  parameter int PIXEL_WIDTH = 8,
  parameter int Y_OFFSET    = 0
) (
  input  logic                     clk,
  input  logic                     resetb,
  input  logic                     enable,
  input  logic                     dvi,
  input  logic [`DTYPE_WIDTH-1:0]  dtypei,
  input  logic [PIXEL_WIDTH-1:0]   y,
  input  logic [PIXEL_WIDTH-1:0]   u,
  input  logic [PIXEL_WIDTH-1:0]   v,
  input  logic [15:0]              meta_datai,
  output logic                     dvo,
  output logic [`DTYPE_WIDTH-1:0]  dtypeo,
  output logic [2*PIXEL_WIDTH-1:0] datao,
  output logic [15:0]              meta_datao
);

  localparam int PW = PIXEL_WIDTH;
  localparam int DW = `DTYPE_WIDTH;

  // XOR with the MSB is the same as adding 2^(PW-1) modulo 2^PW.
  localparam logic [PW-1:0] C_MSB = {1'b1, {(PW-1){1'b0}}};
  localparam logic [31:0]   Y_MAX = 32'((64'd1 << PW) - 64'd1);

  typedef enum logic {
    ST_EVEN = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  state_t state_reg, state_next;

  // Held even pixel, waiting for its odd partner.
  logic [PW-1:0] hold_y_reg, hold_u_reg, hold_v_reg;
  logic [DW-1:0] hold_dtype_reg;
  logic [15:0]   hold_meta_reg;
  logic          hold_load;

  // Odd pixel of a completed pair, emitted one cycle after its even partner.
  logic            odd_valid_reg;
  logic [2*PW-1:0] odd_data_reg;
  logic [DW-1:0]   odd_dtype_reg;
  logic [15:0]     odd_meta_reg;

  // Non-image beat delay stage; two cycles keeps it behind any flush.
  logic            oth_valid_reg;
  logic [2*PW-1:0] oth_data_reg;
  logic [DW-1:0]   oth_dtype_reg;
  logic [15:0]     oth_meta_reg;

  // Beat classification.
  logic is_image, is_other;
  assign is_image = dvi && `DTYPE_IS_IMAGE(dtypei);
  assign is_other = dvi && !is_image;

  // Emission sources for the output register. The pairing schedule keeps
  // these mutually exclusive for any legal input sequence.
  logic emit_even, emit_flush, emit_odd, emit_other, emit_bypass;
  assign emit_even   = enable && (state_reg == ST_HOLD) && is_image;
  assign emit_flush  = enable && (state_reg == ST_HOLD) && !is_image;
  assign emit_odd    = odd_valid_reg;
  assign emit_other  = oth_valid_reg;
  assign emit_bypass = !enable && dvi;

  // Chroma averaging at PW+1 bits: (a + b + 1) >>> 1. Taking bits [PW:1] of
  // the two's-complement sum is the arithmetic shift, and the result always
  // fits back into PW bits.
  logic [PW:0]   u_sum, v_sum;
  logic [PW-1:0] u_avg, v_avg;
  assign u_sum = {hold_u_reg[PW-1], hold_u_reg} + {u[PW-1], u} + {{PW{1'b0}}, 1'b1};
  assign v_sum = {hold_v_reg[PW-1], hold_v_reg} + {v[PW-1], v} + {{PW{1'b0}}, 1'b1};
  assign u_avg = u_sum[PW:1];
  assign v_avg = v_sum[PW:1];

  // Luma offset with saturation to full scale.
  function automatic logic [PW-1:0] y_sat(input logic [PW-1:0] yin);
    logic [31:0] s;
    s = 32'(yin) + 32'(Y_OFFSET);
    if (s > Y_MAX) begin
      s = Y_MAX;
    end
    return s[PW-1:0];
  endfunction

  logic [PW-1:0] y_hold_sat, y_in_sat;
  assign y_hold_sat = y_sat(hold_y_reg);
  assign y_in_sat   = y_sat(y);

  // -------------------------------------------------------------------------
  // Pair FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state_reg <= ST_EVEN;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    hold_load  = 1'b0;
    if (!enable) begin
      state_next = ST_EVEN;
    end else begin
      case (state_reg)
        ST_EVEN: begin
          if (is_image) begin
            state_next = ST_HOLD;
            hold_load  = 1'b1;
          end
        end
        ST_HOLD: begin
          // Pair completes, or the held pixel is flushed: either way the
          // next image beat starts a new pair.
          state_next = ST_EVEN;
        end
        default: begin
          state_next = ST_EVEN;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Held even pixel
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      hold_y_reg     <= '0;
      hold_u_reg     <= '0;
      hold_v_reg     <= '0;
      hold_dtype_reg <= '0;
      hold_meta_reg  <= '0;
    end else if (hold_load) begin
      hold_y_reg     <= y;
      hold_u_reg     <= u;
      hold_v_reg     <= v;
      hold_dtype_reg <= dtypei;
      hold_meta_reg  <= meta_datai;
    end
  end

  // -------------------------------------------------------------------------
  // Odd-pixel and non-image delay stages
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      odd_valid_reg <= 1'b0;
      odd_data_reg  <= '0;
      odd_dtype_reg <= '0;
      odd_meta_reg  <= '0;
    end else begin
      odd_valid_reg <= emit_even;
      if (emit_even) begin
        odd_data_reg  <= {v_avg ^ C_MSB, y_in_sat};
        odd_dtype_reg <= dtypei;
        odd_meta_reg  <= meta_datai;
      end
    end
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      oth_valid_reg <= 1'b0;
      oth_data_reg  <= '0;
      oth_dtype_reg <= '0;
      oth_meta_reg  <= '0;
    end else begin
      oth_valid_reg <= enable && is_other;
      if (enable && is_other) begin
        oth_data_reg  <= {u, y};
        oth_dtype_reg <= dtypei;
        oth_meta_reg  <= meta_datai;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Output register: datao/dtypeo/meta_datao hold between emissions.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      dvo        <= 1'b0;
      dtypeo     <= '0;
      datao      <= '0;
      meta_datao <= '0;
    end else begin
      dvo <= emit_bypass || emit_even || emit_flush || emit_odd || emit_other;
      if (emit_bypass) begin
        datao      <= {u, y};
        dtypeo     <= dtypei;
        meta_datao <= meta_datai;
      end else if (emit_even) begin
        datao      <= {u_avg ^ C_MSB, y_hold_sat};
        dtypeo     <= hold_dtype_reg;
        meta_datao <= hold_meta_reg;
      end else if (emit_flush) begin
        // Unpaired pixel keeps its own U; its V is dropped.
        datao      <= {hold_u_reg ^ C_MSB, y_hold_sat};
        dtypeo     <= hold_dtype_reg;
        meta_datao <= hold_meta_reg;
      end else if (emit_odd) begin
        datao      <= odd_data_reg;
        dtypeo     <= odd_dtype_reg;
        meta_datao <= odd_meta_reg;
      end else if (emit_other) begin
        datao      <= oth_data_reg;
        dtypeo     <= oth_dtype_reg;
        meta_datao <= oth_meta_reg;
      end
    end
  end

endmodule

// File: tb/tb_yuv444_to_422.sv
`timescale 1ns/1ps

`ifndef DTYPE_WIDTH
`define DTYPE_WIDTH 4
`endif
`ifndef DTYPE_IS_IMAGE
`define DTYPE_IS_IMAGE(d) (((d) == 4'h1) || ((d) == 4'h2))
`endif

module tb_yuv444_to_422;

  logic        clk = 1'b0;
  logic        resetb = 1'b0;
  logic        enable = 1'b1;
  logic        dvi = 1'b0;
  logic [3:0]  dtypei = '0;
  logic [7:0]  y = '0, u = '0, v = '0;
  logic [15:0] meta_datai = '0;

  logic        dvo0, dvo16;
  logic [3:0]  dtypeo0, dtypeo16;
  logic [15:0] datao0, datao16;
  logic [15:0] meta0, meta16;

  yuv444_to_422 #(.PIXEL_WIDTH(8), .Y_OFFSET(0)) dut0 (
    .clk(clk), .resetb(resetb), .enable(enable), .dvi(dvi), .dtypei(dtypei),
    .y(y), .u(u), .v(v), .meta_datai(meta_datai),
    .dvo(dvo0), .dtypeo(dtypeo0), .datao(datao0), .meta_datao(meta0)
  );

  yuv444_to_422 #(.PIXEL_WIDTH(8), .Y_OFFSET(16)) dut16 (
    .clk(clk), .resetb(resetb), .enable(enable), .dvi(dvi), .dtypei(dtypei),
    .y(y), .u(u), .v(v), .meta_datai(meta_datai),
    .dvo(dvo16), .dtypeo(dtypeo16), .datao(datao16), .meta_datao(meta16)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_bad = 0;

  // ---------------- scoreboard ----------------
  typedef struct {
    int          cyc;
    logic [15:0] data;
    logic [3:0]  dt;
    logic [15:0] meta;
  } exp_t;

  exp_t exp_q[$];

  function automatic void push_exp(int c, logic [15:0] d, logic [3:0] t, logic [15:0] m);
    exp_t e;
    e.cyc = c; e.data = d; e.dt = t; e.meta = m;
    exp_q.push_back(e);
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (resetb) begin
      if (dvo0) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_out cyc=%0d got data=%h dt=%h meta=%h, required no output",
                   cyc, datao0, dtypeo0, meta0);
        end else begin
          e = exp_q.pop_front();
          if (e.cyc != cyc || datao0 != e.data || dtypeo0 != e.dt || meta0 != e.meta) begin
            n_bad++;
            $display("FAIL out_beat got cyc=%0d data=%h dt=%h meta=%h, required cyc=%0d data=%h dt=%h meta=%h",
                     cyc, datao0, dtypeo0, meta0, e.cyc, e.data, e.dt, e.meta);
          end else begin
            $display("beat cyc=%0d data=%h dt=%h meta=%h ok", cyc, datao0, dtypeo0, meta0);
          end
        end
      end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
        e = exp_q.pop_front();
        n_vec++;
        n_bad++;
        $display("FAIL missing_out cyc=%0d got dvo=0, required data=%h dt=%h meta=%h at cyc=%0d",
                 cyc, e.data, e.dt, e.meta, e.cyc);
      end
    end
  end

  // At most one emission source active per cycle.
  always @(negedge clk) begin
    if (resetb && ($countones({dut0.emit_even, dut0.emit_flush, dut0.emit_odd,
                               dut0.emit_other, dut0.emit_bypass}) > 1)) begin
      n_bad++;
      $display("FAIL collision cyc=%0d got %b, required at most one source",
               cyc, {dut0.emit_even, dut0.emit_flush, dut0.emit_odd, dut0.emit_other, dut0.emit_bypass});
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
    n_vec++;
    if (got !== req) begin
      n_bad++;
      $display("FAIL %s got=%h required=%h", name, got, req);
    end else begin
      $display("check %s = %h ok", name, got);
    end
  endtask

  // ---------------- reference model (Y_OFFSET = 0 instance) ----------------
  bit          m_hold = 0;
  bit          m_en = 1;
  logic [7:0]  m_y, m_u, m_v;
  logic [3:0]  m_dt;
  logic [15:0] m_meta;

  function automatic logic [7:0] cavg(logic [7:0] a, logic [7:0] b);
    int sa, sb, s, q;
    sa = $signed(a);
    sb = $signed(b);
    s  = sa + sb + 1;
    q  = (s >= 0) ? (s / 2) : -((1 - s) / 2);   // floor(s/2)
    return 8'((q + 128) & 255);
  endfunction

  function automatic logic [7:0] cofs(logic [7:0] a);
    int sa;
    sa = $signed(a);
    return 8'((sa + 128) & 255);
  endfunction

  function automatic logic [7:0] ysat(logic [7:0] yy, int off);
    int s;
    s = int'(yy) + off;
    return (s > 255) ? 8'hFF : 8'(s);
  endfunction

  task automatic model_beat(input bit dv, input logic [3:0] dt, input logic [7:0] yy,
                            input logic [7:0] uu, input logic [7:0] vv, input logic [15:0] m);
    bit img;
    int c;
    c   = cyc;
    img = dv && `DTYPE_IS_IMAGE(dt);
    if (!m_en) begin
      if (dv) push_exp(c + 1, {uu, yy}, dt, m);
    end else if (m_hold) begin
      m_hold = 0;
      if (img) begin
        push_exp(c + 1, {cavg(m_u, uu), ysat(m_y, 0)}, m_dt, m_meta);
        push_exp(c + 2, {cavg(m_v, vv), ysat(yy, 0)}, dt, m);
      end else begin
        push_exp(c + 1, {cofs(m_u), ysat(m_y, 0)}, m_dt, m_meta);
        if (dv) push_exp(c + 2, {uu, yy}, dt, m);
      end
    end else if (img) begin
      m_hold = 1;
      m_y = yy; m_u = uu; m_v = vv; m_dt = dt; m_meta = m;
    end else if (dv) begin
      push_exp(c + 2, {uu, yy}, dt, m);
    end
  endtask

  task automatic drive(input bit dv, input logic [3:0] dt, input logic [7:0] yy,
                       input logic [7:0] uu, input logic [7:0] vv, input logic [15:0] m);
    model_beat(dv, dt, yy, uu, vv, m);
    dvi = dv; dtypei = dt; y = yy; u = uu; v = vv; meta_datai = m;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 4'h0, 8'h00, 8'h00, 8'h00, 16'h0000);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit          dv;
    logic [3:0]  dt;
    logic [7:0]  y, u, v;
    logic [15:0] meta;
    int          n;
    int          l0;
    logic [15:0] d0;
    logic [3:0]  t0;
    logic [15:0] m0;
    int          l1;
    logic [15:0] d1;
    logic [3:0]  t1;
    logic [15:0] m1;
  } vec_t;

  function automatic vec_t mk(bit dv, logic [3:0] dt, logic [7:0] yy, logic [7:0] uu,
                              logic [7:0] vv, logic [15:0] m, int n,
                              int l0, logic [15:0] d0, logic [3:0] t0, logic [15:0] m0,
                              int l1, logic [15:0] d1, logic [3:0] t1, logic [15:0] m1);
    vec_t r;
    r.dv = dv; r.dt = dt; r.y = yy; r.u = uu; r.v = vv; r.meta = m; r.n = n;
    r.l0 = l0; r.d0 = d0; r.t0 = t0; r.m0 = m0;
    r.l1 = l1; r.d1 = d1; r.t1 = t1; r.m1 = m1;
    return r;
  endfunction

  vec_t tbl[16];

  initial begin
    int c0;

    // pair from the worked example, then odd-length row tail
    tbl[0]  = mk(1, 4'h1, 8'd100, 8'hF6, 8'h14, 16'h0100, 0, 0, 16'h0, 4'h0, 16'h0, 0, 16'h0, 4'h0, 16'h0);
    tbl[1]  = mk(1, 4'h1, 8'd102, 8'hEC, 8'h1F, 16'h0101, 2, 1, 16'h7164, 4'h1, 16'h0100, 2, 16'h9A66, 4'h1, 16'h0101);
    tbl[2]  = mk(1, 4'h1, 8'd50,  8'h80, 8'h00, 16'h0102, 0, 0, 16'h0, 4'h0, 16'h0, 0, 16'h0, 4'h0, 16'h0);
    tbl[3]  = mk(0, 4'h0, 8'd0,   8'h00, 8'h00, 16'h0000, 1, 1, 16'h0032, 4'h1, 16'h0102, 0, 16'h0, 4'h0, 16'h0);
    tbl[4]  = mk(0, 4'h0, 8'd0,   8'h00, 8'h00, 16'h0000, 0, 0, 16'h0, 4'h0, 16'h0, 0, 16'h0, 4'h0, 16'h0);
    // held pixel interrupted by a header: flush, then header
    tbl[5]  = mk(1, 4'h1, 8'd10,  8'h00, 8'h00, 16'h0200, 0, 0, 16'h0, 4'h0, 16'h0, 0, 16'h0, 4'h0, 16'h0);
    tbl[6]  = mk(1, 4'h8, 8'hAA,  8'h55, 8'h00, 16'h0300, 2, 1, 16'h800A, 4'h1, 16'h0200, 2, 16'h55AA, 4'h8, 16'h0300);
    // chroma extremes
    tbl[7]  = mk(1, 4'h1, 8'd200, 8'h7F, 8'h7F, 16'h0400, 0, 0, 16'h0, 4'h0, 16'h0, 0, 16'h0, 4'h0, 16'h0);
    tbl[8]  = mk(1, 4'h2, 8'd201, 8'h7F, 8'h7F, 16'h0401, 2, 1, 16'hFFC8, 4'h1, 16'h0400, 2, 16'hFFC9, 4'h2, 16'h0401);
    tbl[9]  = mk(1, 4'h1, 8'd1,   8'h80, 8'h80, 16'h0402, 0, 0, 16'h0, 4'h0, 16'h0, 0, 16'h0, 4'h0, 16'h0);
    tbl[10] = mk(1, 4'h1, 8'd2,   8'h80, 8'h80, 16'h0403, 2, 1, 16'h0001, 4'h1, 16'h0402, 2, 16'h0002, 4'h1, 16'h0403);
    // rounding across zero
    tbl[11] = mk(1, 4'h1, 8'd3,   8'hFF, 8'h00, 16'h0404, 0, 0, 16'h0, 4'h0, 16'h0, 0, 16'h0, 4'h0, 16'h0);
    tbl[12] = mk(1, 4'h1, 8'd4,   8'h00, 8'h01, 16'h0405, 2, 1, 16'h8003, 4'h1, 16'h0404, 2, 16'h8104, 4'h1, 16'h0405);
    // header with nothing held
    tbl[13] = mk(1, 4'h8, 8'h12,  8'h34, 8'h00, 16'h0500, 1, 2, 16'h3412, 4'h8, 16'h0500, 0, 16'h0, 4'h0, 16'h0);
    tbl[14] = mk(0, 4'h0, 8'd0,   8'h00, 8'h00, 16'h0000, 0, 0, 16'h0, 4'h0, 16'h0, 0, 16'h0, 4'h0, 16'h0);
    tbl[15] = mk(0, 4'h0, 8'd0,   8'h00, 8'h00, 16'h0000, 0, 0, 16'h0, 4'h0, 16'h0, 0, 16'h0, 4'h0, 16'h0);

    // ---------------- reset values ----------------
    repeat (3) @(posedge clk);
    #1;
    chk("rst_dvo", 32'(dvo0), 32'h0);
    chk("rst_datao", 32'(datao0), 32'h0);
    chk("rst_dtypeo", 32'(dtypeo0), 32'h0);
    chk("rst_meta", 32'(meta0), 32'h0);
    resetb = 1'b1;
    @(posedge clk); #1;

    // ---------------- table ----------------
    for (int i = 0; i < 16; i++) begin
      c0 = cyc;
      dvi = tbl[i].dv; dtypei = tbl[i].dt; y = tbl[i].y; u = tbl[i].u; v = tbl[i].v;
      meta_datai = tbl[i].meta;
      if (tbl[i].n >= 1) push_exp(c0 + tbl[i].l0, tbl[i].d0, tbl[i].t0, tbl[i].m0);
      if (tbl[i].n >= 2) push_exp(c0 + tbl[i].l1, tbl[i].d1, tbl[i].t1, tbl[i].m1);
      @(posedge clk); #1;
    end

    // ---------------- rows with headers ----------------
    for (int r = 0; r < 10; r++) begin
      int len;
      drive(1, 4'h8, 8'($urandom), 8'($urandom), 8'($urandom), {8'hE0, 8'(r)});
      len = (r == 0) ? 6 : $urandom_range(1, 7);
      for (int p = 0; p < len; p++) begin
        drive(1, (p == len - 1) ? 4'h2 : 4'h1, 8'($urandom), 8'($urandom), 8'($urandom),
              {8'(r), 8'(p)});
      end
      idle($urandom_range(0, 2));
    end
    idle(4);

    // ---------------- reset while holding ----------------
    drive(1, 4'h1, 8'd120, 8'h10, 8'h20, 16'h0600);
    drive(1, 4'h1, 8'd121, 8'h30, 8'h40, 16'h0601);
    drive(1, 4'h1, 8'd122, 8'h50, 8'h60, 16'h0602);   // held when reset hits
    resetb = 1'b0;
    dvi = 1'b0;
    exp_q.delete();
    m_hold = 0;
    #1;
    chk("midrst_dvo", 32'(dvo0), 32'h0);
    chk("midrst_datao", 32'(datao0), 32'h0);
    chk("midrst_dtypeo", 32'(dtypeo0), 32'h0);
    chk("midrst_meta", 32'(meta0), 32'h0);
    @(posedge clk);
    @(posedge clk); #1;
    resetb = 1'b1;
    idle(3);
    drive(1, 4'h1, 8'd130, 8'h02, 8'h04, 16'h0700);
    drive(1, 4'h1, 8'd131, 8'h06, 8'h08, 16'h0701);
    idle(3);

    // ---------------- bypass ----------------
    m_en = 0;
    enable = 1'b0;
    drive(1, 4'h1, 8'd100, 8'hF6, 8'h14, 16'h0800);
    chk("bypass_first", 32'(datao0), 32'h0000F664);
    drive(1, 4'h1, 8'd101, 8'h80, 8'h7F, 16'h0801);
    drive(1, 4'h8, 8'h5A, 8'hA5, 8'h00, 16'h0802);
    idle(1);
    drive(1, 4'h1, 8'd255, 8'h7F, 8'h80, 16'h0803);
    idle(2);
    m_en = 1;
    enable = 1'b1;
    idle(2);

    // ---------------- Y offset saturation (Y_OFFSET=16 instance) ----------------
    drive(1, 4'h1, 8'd250, 8'h00, 8'h00, 16'h0900);
    drive(1, 4'h1, 8'd10,  8'h00, 8'h00, 16'h0901);
    dvi = 1'b0;
    @(negedge clk);
    chk("yoff_even_dvo", 32'(dvo16), 32'h1);
    chk("yoff_even_data", 32'(datao16), 32'h000080FF);
    @(negedge clk);
    chk("yoff_odd_dvo", 32'(dvo16), 32'h1);
    chk("yoff_odd_data", 32'(datao16), 32'h0000801A);
    @(posedge clk); #1;
    idle(4);

    chk("drain_empty", 32'(exp_q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
